bcd_updown_counter_n: RTL and testbench



---
 rtl/bcd_updown_counter_n.sv | 73 +++++++
 tb/tb_bcd_updown_counter_n.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/bcd_updown_counter_n.sv
// bcd_updown_counter_n: DIGITS-decade BCD up/down counter wrapping between 0 and BOUND.
// It has a validated synchronous load and a combinational terminal-count carry/borrow.
// Build option BCD_CNT_SATURATE_EN makes the counter hold at the terminal value instead of wrapping.
module bcd_updown_counter_n #(
    parameter int unsigned             DIGITS = 4,
    parameter logic [4*DIGITS-1:0]     BOUND  = {DIGITS{4'h9}}
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ena,
    input  logic                  updown,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   cnt,
    output logic                  carry,
    output logic                  load_err
);
    localparam int unsigned W = 4 * DIGITS;

    logic [W-1:0]      cnt_q, cnt_d;
    logic [W-1:0]      inc_val, dec_val;
    logic [DIGITS:0]   nines_below, zeros_below;
    logic [DIGITS-1:0] nib_ok;
    logic              load_ok, at_max, at_zero, terminal;

    assign nines_below[0] = 1'b1;
    assign zeros_below[0] = 1'b1;

    // Per-decade ripple: a digit moves only when every lower digit sits at its rollover value.
    for (genvar i = 0; i < DIGITS; i++) begin : g_dig
        logic [3:0] d;
        assign d = cnt_q[4*i +: 4];
        assign nines_below[i+1] = nines_below[i] & (d == 4'd9);
        assign zeros_below[i+1] = zeros_below[i] & (d == 4'd0);
        assign inc_val[4*i +: 4] = !nines_below[i] ? d : ((d == 4'd9) ? 4'd0 : d + 4'd1);
        assign dec_val[4*i +: 4] = !zeros_below[i] ? d : ((d == 4'd0) ? 4'd9 : d - 4'd1);
        assign nib_ok[i] = (load_val[4*i +: 4] <= 4'd9);
    end

    // With every nibble a legal BCD digit, a plain unsigned compare orders values MSD first.
    assign load_ok  = (&nib_ok) && (load_val <= BOUND);
    assign at_max   = (cnt_q == BOUND);
    assign at_zero  = (cnt_q == '0);
    assign terminal = updown ? at_zero : at_max;

    assign load_err = load && !load_ok;
    assign carry    = ena && !load && terminal;
    assign cnt      = cnt_q;

    // Next count: load beats stepping; terminal steps wrap (or hold when saturating).
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            if (load_ok) cnt_d = load_val;
        end else if (ena) begin
            if (terminal) begin
`ifdef BCD_CNT_SATURATE_EN
                cnt_d = cnt_q;
`else
                cnt_d = updown ? BOUND : '0;
`endif
            end else begin
                cnt_d = updown ? dec_val : inc_val;
            end
        end
    end

    // Count register, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
endmodule

// File: tb/tb_bcd_updown_counter_n.sv
module tb_bcd_updown_counter_n;
    logic        clk = 1'b0;
    logic        reset, ena, updown, load;
    logic [11:0] load_val, cnt;
    logic        carry, load_err;
    int          total = 0;
    int          bad   = 0;

    bcd_updown_counter_n #(.DIGITS(3), .BOUND(12'h359)) dut (
        .clk(clk), .reset(reset), .ena(ena), .updown(updown), .load(load),
        .load_val(load_val), .cnt(cnt), .carry(carry), .load_err(load_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_load(input logic [11:0] v);
        load = 1'b1; load_val = v; ena = 1'b0; tick(); load = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; ena = 1'b0; updown = 1'b0; load = 1'b0; load_val = '0;
        #2;
        total++; if (cnt !== 12'h000) begin bad++; $display("FAIL rst_cnt got=%h exp=000", cnt); end
        total++; if (carry !== 1'b0) begin bad++; $display("FAIL rst_carry got=%b exp=0", carry); end
        total++; if (load_err !== 1'b0) begin bad++; $display("FAIL rst_lerr got=%b exp=0", load_err); end
        ena = 1'b1; updown = 1'b1; #1;
        total++; if (carry !== 1'b1) begin bad++; $display("FAIL rst_borrow got=%b exp=1", carry); end
        load = 1'b1; load_val = 12'h3A0; #1;
        total++; if (load_err !== 1'b1) begin bad++; $display("FAIL rst_lerr_follow got=%b exp=1", load_err); end
        total++; if (carry !== 1'b0) begin bad++; $display("FAIL rst_carry_load got=%b exp=0", carry); end
        load = 1'b0; ena = 1'b0; updown = 1'b0; load_val = '0;
        tick();
        reset = 1'b0; #1;
        total++; if (cnt !== 12'h000) begin bad++; $display("FAIL rst_release got=%h exp=000", cnt); end
    endtask

    task automatic test_reset_mid();
        do_load(12'h127);
        total++; if (cnt !== 12'h127) begin bad++; $display("FAIL mid_load got=%h exp=127", cnt); end
        ena = 1'b1; updown = 1'b0;
        #1 reset = 1'b1;
        #1;
        total++; if (cnt !== 12'h000) begin bad++; $display("FAIL mid_async got=%h exp=000", cnt); end
        reset = 1'b0; #1;
        total++; if (cnt !== 12'h000) begin bad++; $display("FAIL mid_nostep got=%h exp=000", cnt); end
        tick();
        total++; if (cnt !== 12'h001) begin bad++; $display("FAIL mid_resume got=%h exp=001", cnt); end
        ena = 1'b0;
    endtask

    task automatic test_up();
        do_load(12'h358);
        ena = 1'b1; updown = 1'b0; #1;
        total++; if (carry !== 1'b0) begin bad++; $display("FAIL up_c358 got=%b exp=0", carry); end
        tick();
        total++; if (cnt !== 12'h359) begin bad++; $display("FAIL up_359 got=%h exp=359", cnt); end
        total++; if (carry !== 1'b1) begin bad++; $display("FAIL up_c359 got=%b exp=1", carry); end
        tick();
        total++; if (cnt !== 12'h000) begin bad++; $display("FAIL up_wrap got=%h exp=000", cnt); end
        total++; if (carry !== 1'b0) begin bad++; $display("FAIL up_c000 got=%b exp=0", carry); end
        ena = 1'b0;
        do_load(12'h099);
        ena = 1'b1; tick(); ena = 1'b0;
        total++; if (cnt !== 12'h100) begin bad++; $display("FAIL up_099 got=%h exp=100", cnt); end
        tick();
        total++; if (cnt !== 12'h100) begin bad++; $display("FAIL hold got=%h exp=100", cnt); end
    endtask

    task automatic test_down();
        do_load(12'h100);
        ena = 1'b1; updown = 1'b1; #1;
        total++; if (carry !== 1'b0) begin bad++; $display("FAIL dn_c100 got=%b exp=0", carry); end
        tick(); ena = 1'b0;
        total++; if (cnt !== 12'h099) begin bad++; $display("FAIL dn_100 got=%h exp=099", cnt); end
        do_load(12'h000);
        ena = 1'b1; updown = 1'b1; #1;
        total++; if (carry !== 1'b1) begin bad++; $display("FAIL dn_c000 got=%b exp=1", carry); end
        tick(); ena = 1'b0; updown = 1'b0;
        total++; if (cnt !== 12'h359) begin bad++; $display("FAIL dn_wrap got=%h exp=359", cnt); end
    endtask

    task automatic test_load_valid();
        do_load(12'h123);
        load = 1'b1; load_val = 12'h3A0; #1;
        total++; if (load_err !== 1'b1) begin bad++; $display("FAIL lv_3A0_err got=%b exp=1", load_err); end
        tick();
        total++; if (cnt !== 12'h123) begin bad++; $display("FAIL lv_3A0_cnt got=%h exp=123", cnt); end
        load_val = 12'h360; #1;
        total++; if (load_err !== 1'b1) begin bad++; $display("FAIL lv_360_err got=%b exp=1", load_err); end
        tick();
        total++; if (cnt !== 12'h123) begin bad++; $display("FAIL lv_360_cnt got=%h exp=123", cnt); end
        load_val = 12'h200; #1;
        total++; if (load_err !== 1'b0) begin bad++; $display("FAIL lv_200_err got=%b exp=0", load_err); end
        tick(); load = 1'b0;
        total++; if (cnt !== 12'h200) begin bad++; $display("FAIL lv_200_cnt got=%h exp=200", cnt); end
        #1;
        total++; if (load_err !== 1'b0) begin bad++; $display("FAIL lv_idle_err got=%b exp=0", load_err); end
    endtask

    task automatic test_load_priority();
        do_load(12'h359);
        load = 1'b1; load_val = 12'h005; ena = 1'b1; updown = 1'b0; #1;
        total++; if (carry !== 1'b0) begin bad++; $display("FAIL pri_carry got=%b exp=0", carry); end
        total++; if (load_err !== 1'b0) begin bad++; $display("FAIL pri_err got=%b exp=0", load_err); end
        tick(); load = 1'b0; ena = 1'b0;
        total++; if (cnt !== 12'h005) begin bad++; $display("FAIL pri_cnt got=%h exp=005", cnt); end
    endtask

    task automatic test_terminal();
        logic [11:0] exp_cnt [3];
        logic        exp_c   [3];
`ifdef BCD_CNT_SATURATE_EN
        exp_cnt = '{12'h359, 12'h359, 12'h359};
        exp_c   = '{1'b1, 1'b1, 1'b1};
`else
        exp_cnt = '{12'h000, 12'h001, 12'h002};
        exp_c   = '{1'b1, 1'b0, 1'b0};
`endif
        do_load(12'h359);
        ena = 1'b1; updown = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            total++; if (carry !== exp_c[k]) begin bad++; $display("FAIL term_carry%0d got=%b exp=%b", k, carry, exp_c[k]); end
            tick();
            total++; if (cnt !== exp_cnt[k]) begin bad++; $display("FAIL term_cnt%0d got=%h exp=%h", k, cnt, exp_cnt[k]); end
        end
`ifdef BCD_CNT_SATURATE_EN
        updown = 1'b1; #1;
        total++; if (carry !== 1'b0) begin bad++; $display("FAIL sat_rev_carry got=%b exp=0", carry); end
        tick();
        total++; if (cnt !== 12'h358) begin bad++; $display("FAIL sat_rev_cnt got=%h exp=358", cnt); end
`endif
        ena = 1'b0; updown = 1'b0;
    endtask

    initial begin
        test_reset();
        test_reset_mid();
        test_up();
        test_down();
        test_load_valid();
        test_load_priority();
        test_terminal();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
